// File: rtl/sdhci_cmd_pkg.sv
// Shared constants and state type for the SD host CMD-line write path.
package sdhci_cmd_pkg;

  localparam int unsigned CMD_FRAME_LEN = 48;
  localparam int unsigned CMD_CRC_START = 40;
  localparam int unsigned CMD_CRC_LEN   = 7;

  // x^7 + x^3 + 1 without the implicit x^7 term
  localparam logic [CMD_CRC_LEN-1:0] CMD_CRC_POLY = 7'h09;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StData,
    StCrc,
    StEnd
  } cmd_wr_state_e;

endpackage

// File: rtl/sd_crc7_ser.sv
// Serial CRC7 generator: accumulates one bit per tick, then shifts the remainder out MSb first.
module sd_crc7_ser
  import sdhci_cmd_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic clk_en_i,
  input  logic clr_i,
  input  logic input_en_i,
  input  logic dat_ser_i,
  input  logic shift_out_i,
  output logic crc_ser_o
);

  logic [CMD_CRC_LEN-1:0] r_crc;
  logic [CMD_CRC_LEN-1:0] w_crc_d;
  logic                   w_fb;

  always_comb begin
    w_fb    = dat_ser_i ^ r_crc[CMD_CRC_LEN-1];
    w_crc_d = r_crc;
    // Clear is not gated by the tick: it happens in the accept cycle.
    if (clr_i) begin
      w_crc_d = '0;
    end else if (clk_en_i) begin
      if (shift_out_i) begin
        w_crc_d = {r_crc[CMD_CRC_LEN-2:0], 1'b0};
      end else if (input_en_i) begin
        w_crc_d = {r_crc[CMD_CRC_LEN-2:0], 1'b0} ^ (w_fb ? CMD_CRC_POLY : '0);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_crc <= '0;
    end else begin
      r_crc <= w_crc_d;
    end
  end

  assign crc_ser_o = r_crc[CMD_CRC_LEN-1];

endmodule

// File: rtl/sd_cmd_write_ctrl.sv
// CMD-line write sequencer: accepts one command and serialises its 48-bit frame, one bit per tick.
module sd_cmd_write_ctrl
  import sdhci_cmd_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clk_en_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [5:0]  cmd_index_i,
  input  logic [31:0] cmd_arg_i,
  output logic        cmd_o,
  output logic        cmd_oe_o,
  output logic        busy_o,
  output logic        done_o
);

  // r_cnt holds the frame index of the bit currently on the line.
  localparam logic [5:0] LastDataCnt = 6'(CMD_CRC_START - 1);
  localparam logic [5:0] LastCrcCnt  = 6'(CMD_FRAME_LEN - 2);

  cmd_wr_state_e            r_state, w_state_d;
  logic [CMD_CRC_START-1:0] r_shift, w_shift_d;
  logic [5:0]               r_cnt, w_cnt_d;
  logic                     r_cmd, w_cmd_d;
  logic                     r_oe, w_oe_d;
  logic                     r_ready, w_ready_d;
  logic                     r_busy, w_busy_d;
  logic                     r_done, w_done_d;

  logic w_accept;
  logic w_crc_clr;
  logic w_crc_in_en;
  logic w_crc_shift;
  logic w_crc_dat;
  logic w_crc_bit;

  assign w_accept = cmd_valid_i && r_ready;

  always_comb begin
    w_state_d   = r_state;
    w_shift_d   = r_shift;
    w_cnt_d     = r_cnt;
    w_cmd_d     = r_cmd;
    w_oe_d      = r_oe;
    w_done_d    = 1'b0;
    w_crc_clr   = 1'b0;
    w_crc_in_en = 1'b0;
    w_crc_shift = 1'b0;
    w_crc_dat   = r_shift[CMD_CRC_START-1];

    unique case (r_state)
      StIdle: begin
        // A tick coinciding with accept is deliberately ignored.
        if (w_accept) begin
          w_shift_d = {1'b0, 1'b1, cmd_index_i, cmd_arg_i};
          w_cnt_d   = '0;
          w_crc_clr = 1'b1;
          w_state_d = StWait;
        end
      end
      StWait: begin
        if (clk_en_i) begin
          w_cmd_d     = r_shift[CMD_CRC_START-1];
          w_oe_d      = 1'b1;
          w_crc_in_en = 1'b1;
          w_shift_d   = {r_shift[CMD_CRC_START-2:0], 1'b0};
          w_state_d   = StData;
        end
      end
      StData: begin
        if (clk_en_i) begin
          w_cnt_d = r_cnt + 6'd1;
          if (r_cnt == LastDataCnt) begin
            w_crc_shift = 1'b1;
            w_cmd_d     = w_crc_bit;
            w_state_d   = StCrc;
          end else begin
            w_cmd_d     = r_shift[CMD_CRC_START-1];
            w_crc_in_en = 1'b1;
            w_shift_d   = {r_shift[CMD_CRC_START-2:0], 1'b0};
          end
        end
      end
      StCrc: begin
        if (clk_en_i) begin
          w_cnt_d = r_cnt + 6'd1;
          if (r_cnt == LastCrcCnt) begin
            w_cmd_d   = 1'b1;
            w_state_d = StEnd;
          end else begin
            w_crc_shift = 1'b1;
            w_cmd_d     = w_crc_bit;
          end
        end
      end
      StEnd: begin
        if (clk_en_i) begin
          w_cmd_d   = 1'b1;
          w_oe_d    = 1'b0;
          w_done_d  = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: begin
        w_cmd_d   = 1'b1;
        w_oe_d    = 1'b0;
        w_state_d = StIdle;
      end
    endcase

    w_ready_d = (w_state_d == StIdle);
    w_busy_d  = !w_ready_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_shift <= '0;
      r_cnt   <= '0;
      r_cmd   <= 1'b1;
      r_oe    <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_shift <= w_shift_d;
      r_cnt   <= w_cnt_d;
      r_cmd   <= w_cmd_d;
      r_oe    <= w_oe_d;
      r_ready <= w_ready_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
    end
  end

  sd_crc7_ser u_crc7 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clk_en_i    (clk_en_i),
    .clr_i       (w_crc_clr),
    .input_en_i  (w_crc_in_en),
    .dat_ser_i   (w_crc_dat),
    .shift_out_i (w_crc_shift),
    .crc_ser_o   (w_crc_bit)
  );

  assign cmd_ready_o = r_ready;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign cmd_o       = r_cmd;
  assign cmd_oe_o    = r_oe;

endmodule
